// File: rtl/sam_pkg.sv
// Shared types and default widths for the sample-memory command path.
package sam_pkg;

   localparam int unsigned SAM_ADDR_W = 15;
   localparam int unsigned SAM_DATA_W = 15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_RD_REQ = 3'd2,
      ST_RD_CAP = 3'd3,
      ST_RD_OUT = 3'd4
   } seq_state_t;

   // Decoded host command as produced by instruction_decoder.
   typedef struct packed {
      logic                  wr_en;
      logic                  rd_en;
      logic                  go;
      logic [SAM_ADDR_W-1:0] wr_addr;
      logic [SAM_ADDR_W-1:0] rd_start;
      logic [SAM_ADDR_W-1:0] rd_end;
      logic [SAM_DATA_W-1:0] wr_data;
   } sam_cmd_t;

endpackage

// File: rtl/mem_access_sequencer.sv
// Single master of the sample RAM: single-word writes, read-range arming,
// and streaming of the armed range over a valid/ready interface.
module mem_access_sequencer
   import sam_pkg::*;
#(
   parameter int unsigned ADDR_W = SAM_ADDR_W,
   parameter int unsigned DATA_W = SAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr_en,
   input  logic              cmd_rd_en,
   input  logic              cmd_go,
   input  logic [ADDR_W-1:0] cmd_wr_addr,
   input  logic [ADDR_W-1:0] cmd_rd_start,
   input  logic [ADDR_W-1:0] cmd_rd_end,
   input  logic [DATA_W-1:0] cmd_wr_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              armed,
   output logic              err
);

   seq_state_t        state, state_n;
   logic [ADDR_W-1:0] rd_start, rd_start_n;
   logic [ADDR_W-1:0] rd_end, rd_end_n;
   logic [ADDR_W-1:0] cnt, cnt_n;
   logic              armed_n, err_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [DATA_W-1:0] mem_wdata_n;
   logic              mem_we_n, mem_re_n;
   logic              out_valid_n, out_last_n;
   logic [DATA_W-1:0] out_data_n;
   logic              accept;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Next state plus the value every registered output takes in that state.
   always_comb begin
      state_n     = state;
      rd_start_n  = rd_start;
      rd_end_n    = rd_end;
      cnt_n       = cnt;
      armed_n     = armed;
      err_n       = err;
      mem_addr_n  = '0;
      mem_wdata_n = '0;
      mem_we_n    = 1'b0;
      mem_re_n    = 1'b0;
      out_valid_n = out_valid;
      out_last_n  = out_last;
      out_data_n  = out_data;

      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_wr_en) begin
                  state_n     = ST_WRITE;
                  mem_we_n    = 1'b1;
                  mem_addr_n  = cmd_wr_addr;
                  mem_wdata_n = cmd_wr_data;
               end else if (cmd_rd_en) begin
                  if (cmd_rd_start <= cmd_rd_end) begin
                     rd_start_n = cmd_rd_start;
                     rd_end_n   = cmd_rd_end;
                     armed_n    = 1'b1;
                     err_n      = 1'b0;
                  end else begin
                     armed_n = 1'b0;
                     err_n   = 1'b1;
                  end
               end else if (cmd_go) begin
                  if (armed) begin
                     cnt_n      = rd_start;
                     state_n    = ST_RD_REQ;
                     mem_re_n   = 1'b1;
                     mem_addr_n = rd_start;
                  end else begin
                     err_n = 1'b1;
                  end
               end
            end
         end
         ST_WRITE:  state_n = ST_IDLE;
         ST_RD_REQ: state_n = ST_RD_CAP;
         ST_RD_CAP: begin
            out_data_n  = mem_rdata;
            out_last_n  = (cnt == rd_end);
            out_valid_n = 1'b1;
            state_n     = ST_RD_OUT;
         end
         ST_RD_OUT: begin
            if (out_ready) begin
               out_valid_n = 1'b0;
               out_last_n  = 1'b0;
               // Compare happened in RD_CAP, so the increment never wraps past end.
               if (out_last) begin
                  state_n = ST_IDLE;
               end else begin
                  cnt_n      = cnt + ADDR_W'(1);
                  state_n    = ST_RD_REQ;
                  mem_re_n   = 1'b1;
                  mem_addr_n = cnt + ADDR_W'(1);
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rd_start  <= '0;
         rd_end    <= '0;
         cnt       <= '0;
         armed     <= 1'b0;
         err       <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_n;
         rd_start  <= rd_start_n;
         rd_end    <= rd_end_n;
         cnt       <= cnt_n;
         armed     <= armed_n;
         err       <= err_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         mem_we    <= mem_we_n;
         mem_re    <= mem_re_n;
         out_valid <= out_valid_n;
         out_last  <= out_last_n;
         out_data  <= out_data_n;
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a behavioural single-port RAM.
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic        cmd_wr_en, cmd_rd_en, cmd_go;
   logic [14:0] cmd_wr_addr, cmd_rd_start, cmd_rd_end, cmd_wr_data;
   logic [14:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;
   logic        out_valid, out_ready, out_last;
   logic [14:0] out_data;
   logic        busy, armed, err;

   int n_checks = 0;
   int n_fail   = 0;
   int re_count = 0;
   int both_cnt = 0;

   logic [14:0] ram [0:32767];

   always #5 clk = ~clk;

   mem_access_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_wr_en(cmd_wr_en), .cmd_rd_en(cmd_rd_en), .cmd_go(cmd_go),
      .cmd_wr_addr(cmd_wr_addr), .cmd_rd_start(cmd_rd_start),
      .cmd_rd_end(cmd_rd_end), .cmd_wr_data(cmd_wr_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .busy(busy), .armed(armed), .err(err)
   );

   // RAM model: read data appears one cycle after mem_re.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
      if (mem_re) re_count <= re_count + 1;
      if (mem_we && mem_re) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic wr, input logic rd, input logic go,
                         input logic [14:0] a, input logic [14:0] d,
                         input logic [14:0] s, input logic [14:0] e);
      cmd_valid = 1'b1; cmd_wr_en = wr; cmd_rd_en = rd; cmd_go = go;
      cmd_wr_addr = a; cmd_wr_data = d; cmd_rd_start = s; cmd_rd_end = e;
      tick();
      cmd_valid = 1'b0; cmd_wr_en = 1'b0; cmd_rd_en = 1'b0; cmd_go = 1'b0;
   endtask

   // Consume count words expecting base, base+1, ...; optionally stall every other cycle.
   task automatic stream_check(input string tag, input logic [14:0] base,
                               input int count, input bit toggle);
      int          idx = 0;
      bit          stalled = 1'b0;
      logic [14:0] hold = '0;
      logic [14:0] expv;
      for (int cyc = 0; cyc < 200 && idx < count; cyc++) begin
         out_ready = toggle ? cyc[0] : 1'b1;
         if (stalled) begin
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(out_data), 32'(hold));
         end
         stalled = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               expv = base + 15'(idx);
               chk({tag, "_data"}, 32'(out_data), 32'(expv));
               chk({tag, "_last"}, 32'(out_last), 32'(idx == count - 1));
               idx++;
            end else begin
               stalled = 1'b1;
               hold    = out_data;
            end
         end
         tick();
      end
      chk({tag, "_words"}, 32'(idx), 32'(count));
      out_ready = 1'b1;
   endtask

   int re_snap;
   int words;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr_en = 1'b0; cmd_rd_en = 1'b0; cmd_go = 1'b0;
      cmd_wr_addr = '0; cmd_rd_start = '0; cmd_rd_end = '0; cmd_wr_data = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_armed", 32'(armed), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // Single write: mem_we at N+1, ready back at N+2.
      do_cmd(1, 0, 0, 15'h0108, 15'h211C, '0, '0);
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'h0108);
      chk("wr_data", 32'(mem_wdata), 32'h211C);
      chk("wr_ready_low", 32'(cmd_ready), 32'd0);
      chk("wr_no_re", 32'(mem_re), 32'd0);
      tick();
      chk("wr_ready_back", 32'(cmd_ready), 32'd1);
      chk("wr_we_off", 32'(mem_we), 32'd0);
      chk("wr_addr_zero", 32'(mem_addr), 32'd0);
      chk("wr_data_zero", 32'(mem_wdata), 32'd0);

      // Fill 10..13 with 1..4, arm and stream with out_ready held high.
      for (int i = 0; i < 4; i++) begin
         do_cmd(1, 0, 0, 15'(10 + i), 15'(1 + i), '0, '0);
         tick();
      end
      do_cmd(0, 1, 0, '0, '0, 15'd10, 15'd13);
      chk("arm_armed", 32'(armed), 32'd1);
      chk("arm_err", 32'(err), 32'd0);
      chk("arm_idle", 32'(cmd_ready), 32'd1);
      out_ready = 1'b1;
      do_cmd(0, 0, 1, '0, '0, '0, '0);
      chk("go_re", 32'(mem_re), 32'd1);
      chk("go_addr", 32'(mem_addr), 32'd10);
      chk("go_busy", 32'(busy), 32'd1);
      tick();
      chk("go_no_valid_n2", 32'(out_valid), 32'd0);
      tick();
      chk("go_valid_n3", 32'(out_valid), 32'd1);
      stream_check("s1", 15'd1, 4, 1'b0);
      chk("s1_ready_after", 32'(cmd_ready), 32'd1);
      chk("s1_valid_after", 32'(out_valid), 32'd0);
      chk("s1_armed_kept", 32'(armed), 32'd1);

      // Replay of the same range with back-pressure.
      do_cmd(0, 0, 1, '0, '0, '0, '0);
      stream_check("s2", 15'd1, 4, 1'b1);
      chk("s2_ready_after", 32'(cmd_ready), 32'd1);

      // Inverted range sets err and clears armed; go then never reads.
      do_cmd(0, 1, 0, '0, '0, 15'd5, 15'd4);
      chk("bad_err", 32'(err), 32'd1);
      chk("bad_armed", 32'(armed), 32'd0);
      re_snap = re_count;
      do_cmd(0, 0, 1, '0, '0, '0, '0);
      repeat (4) tick();
      chk("bad_go_no_re", 32'(re_count), 32'(re_snap));
      chk("bad_go_idle", 32'(cmd_ready), 32'd1);
      chk("bad_err_sticky", 32'(err), 32'd1);

      // Top address: exactly one word, no wrap.
      do_cmd(1, 0, 0, 15'h7FFF, 15'h1234, '0, '0);
      tick();
      do_cmd(0, 1, 0, '0, '0, 15'h7FFF, 15'h7FFF);
      chk("top_err_cleared", 32'(err), 32'd0);
      re_snap = re_count;
      do_cmd(0, 0, 1, '0, '0, '0, '0);
      stream_check("top", 15'h1234, 1, 1'b0);
      repeat (3) tick();
      chk("top_one_read", 32'(re_count), 32'(re_snap + 1));
      chk("top_idle", 32'(cmd_ready), 32'd1);

      // All strobes at once: only the write takes effect.
      re_snap = re_count;
      do_cmd(1, 1, 1, 15'd20, 15'h0055, 15'd3, 15'd1);
      chk("prio_we", 32'(mem_we), 32'd1);
      chk("prio_addr", 32'(mem_addr), 32'd20);
      chk("prio_armed", 32'(armed), 32'd1);
      chk("prio_err", 32'(err), 32'd0);
      repeat (3) tick();
      chk("prio_no_re", 32'(re_count), 32'(re_snap));

      // Reset during the third word of range 0..7.
      do_cmd(0, 1, 0, '0, '0, 15'd0, 15'd7);
      out_ready = 1'b1;
      do_cmd(0, 0, 1, '0, '0, '0, '0);
      words = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (out_valid) begin
            if (words == 2) break;
            words++;
         end
         tick();
      end
      chk("mid_reached_3rd", 32'(out_valid && words == 2), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_last", 32'(out_last), 32'd0);
      chk("mid_data", 32'(out_data), 32'd0);
      chk("mid_re", 32'(mem_re), 32'd0);
      chk("mid_addr", 32'(mem_addr), 32'd0);
      chk("mid_armed", 32'(armed), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("mid_ready", 32'(cmd_ready), 32'd1);
      do_cmd(0, 0, 1, '0, '0, '0, '0);
      chk("mid_go_err", 32'(err), 32'd1);
      chk("mid_go_no_re", 32'(mem_re), 32'd0);
      chk("mid_go_idle", 32'(busy), 32'd0);

      chk("never_we_and_re", 32'(both_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
